dog_seq_ctrl: RTL

Sequencer for the two-pass separable DoG filter on a 256x256 8-bit image. It issues read addresses to the image buffer: pass 0 in row order, pass 1 in column order. After each line it inserts pad samples so the filter pipeline is flushed before the next line. It drives the filter's valid/pad/line-start strobes aligned to the 1-cycle memory read latency, waits for the filter to drain between passes, and reports completion only after the line writer signals done.

---
 rtl/dog_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dog_seq_ctrl.sv
// Read-address and strobe sequencer for the two-pass separable DoG filter:
// row-order pass 0, column-order pass 1, per-line pad flush, inter-pass drain.
module dog_seq_ctrl #(
    parameter int IMG_W = 256,
    parameter int PAD   = 6,
    parameter int DRAIN = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_hold,
    input  logic        i_wr_done,
    output logic        o_rd_en,
    output logic [15:0] o_rd_addr,
    output logic        o_buf_sel,
    output logic        o_flt_valid,
    output logic        o_flt_pad,
    output logic        o_flt_sol,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_WAIT_WR = 2'd3;

    localparam logic [8:0] X_PIX     = 9'(IMG_W);
    localparam logic [8:0] X_LAST    = 9'(IMG_W + PAD - 1);
    localparam logic [7:0] LINE_LAST = 8'(IMG_W - 1);
    localparam int         DW        = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN - 1);

    logic [1:0]    r_state;
    logic [8:0]    r_x;
    logic [7:0]    r_line;
    logic          r_pass;
    logic [DW-1:0] r_dcnt;
    logic          r_flt_valid;
    logic          r_flt_pad;
    logic          r_flt_sol;
    logic          r_busy;
    logic          r_done;

    logic w_issue;
    logic w_pix;
    logic w_x_end;
    logic w_line_end;
    logic w_rd_en;

    always_comb begin
        w_issue    = (r_state == S_ISSUE) && !i_hold;
        w_pix      = (r_x < X_PIX);
        w_x_end    = (r_x == X_LAST);
        w_line_end = (r_line == LINE_LAST);
        w_rd_en    = w_issue && w_pix;
    end

    // Pass 1 transposes the coordinate pair so the same counters walk columns.
    always_comb begin
        o_rd_addr = '0;
        if (w_rd_en) begin
            o_rd_addr = r_pass ? {r_x[7:0], r_line} : {r_line, r_x[7:0]};
        end
    end

    assign o_rd_en     = w_rd_en;
    assign o_buf_sel   = r_pass;
    assign o_flt_valid = r_flt_valid;
    assign o_flt_pad   = r_flt_pad;
    assign o_flt_sol   = r_flt_sol;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_line      <= '0;
            r_pass      <= 1'b0;
            r_dcnt      <= '0;
            r_flt_valid <= 1'b0;
            r_flt_pad   <= 1'b0;
            r_flt_sol   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Strobes trail the issue by one cycle to line up with the buffer read latency.
            r_flt_valid <= w_issue;
            r_flt_pad   <= w_issue && !w_pix;
            r_flt_sol   <= w_issue && (r_x == '0);
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ISSUE;
                        r_x     <= '0;
                        r_line  <= '0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!i_hold) begin
                        if (w_x_end) begin
                            r_x    <= '0;
                            r_line <= w_line_end ? '0 : r_line + 8'd1;
                            if (w_line_end) begin
                                r_state <= r_pass ? S_WAIT_WR : S_DRAIN;
                                r_dcnt  <= '0;
                            end
                        end else begin
                            r_x <= r_x + 9'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == D_LAST) begin
                        r_pass  <= 1'b1;
                        r_x     <= '0;
                        r_line  <= '0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_WAIT_WR: begin
                    if (i_wr_done) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
